// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, control bit-field layout,
// per-opcode control constants and the opcode-to-control decoder.
package decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    // Control field widths
    localparam int unsigned WB_W  = 2;
    localparam int unsigned MEM_W = 3;
    localparam int unsigned EX_W  = 4;

    // Bit positions inside each control field
    localparam int unsigned WB_REGWRITE  = 1;
    localparam int unsigned WB_MEMTOREG  = 0;
    localparam int unsigned MEM_BRANCH   = 2;
    localparam int unsigned MEM_MEMREAD  = 1;
    localparam int unsigned MEM_MEMWRITE = 0;
    localparam int unsigned EX_REGDST    = 3;
    localparam int unsigned EX_ALUOP_LSB = 1;
    localparam int unsigned EX_ALUSRC    = 0;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } ctrl_t;

    localparam ctrl_t CTRL_RTYPE = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100};
    localparam ctrl_t CTRL_LW    = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001};
    localparam ctrl_t CTRL_SW    = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001};
    localparam ctrl_t CTRL_BEQ   = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010};
    localparam ctrl_t CTRL_ADDI  = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001};
    localparam ctrl_t CTRL_NOP   = '{wb: 2'b00, mem: 3'b000, ex: 4'b0000};

    // Main control decoder; unknown opcodes become a NOP
    function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op);
        ctrl_t c;
        case (op)
            OP_RTYPE: c = CTRL_RTYPE;
            OP_LW:    c = CTRL_LW;
            OP_SW:    c = CTRL_SW;
            OP_BEQ:   c = CTRL_BEQ;
            OP_ADDI:  c = CTRL_ADDI;
            default:  c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_ld.sv
// Load-use hazard detect: the load in ID/EX writes a register that the
// instruction in ID reads.
//   id_ex_memread_i  latched MemRead of the instruction in EX
//   id_ex_rt_i       destination register of that load
//   rs_i, rt_i       source fields of the instruction in ID
//   use_rt_i         1 when the ID instruction actually reads rt
//   stall_o          combinational stall request
module hazard_unit_ld #(
    parameter int unsigned RAW = 5
) (
    input  logic           id_ex_memread_i,
    input  logic [RAW-1:0] id_ex_rt_i,
    input  logic [RAW-1:0] rs_i,
    input  logic [RAW-1:0] rt_i,
    input  logic           use_rt_i,
    output logic           stall_o
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit  = (id_ex_rt_i == rs_i);
        rt_hit  = use_rt_i && (id_ex_rt_i == rt_i);
        stall_o = id_ex_memread_i && (id_ex_rt_i != '0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/decode_stage_hz.sv
// Instruction decode stage: control decode, sign extension, register file
// with write-through bypass, load-use hazard detection, and the ID/EX latch
// with flush/stall bubbles and downstream hold.
//   clk, rst                 clock, async active-low reset
//   wb_* / mem_wb_write_data register-file write port from WB
//   if_id_instr, if_id_npc   instruction and next PC from IF/ID
//   flush, ex_hold           squash ID instruction / freeze ID/EX
//   stall_out                load-use stall (combinational)
//   id_ex_*                  registered ID/EX bundle
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned RAW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_reg_write,
    input  logic [RAW-1:0]  wb_write_reg_location,
    input  logic [XLEN-1:0] mem_wb_write_data,
    input  logic [31:0]     if_id_instr,
    input  logic [XLEN-1:0] if_id_npc,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall_out,
    output logic [1:0]      id_ex_wb,
    output logic [2:0]      id_ex_mem,
    output logic [3:0]      id_ex_execute,
    output logic [XLEN-1:0] id_ex_npc,
    output logic [XLEN-1:0] id_ex_readdat1,
    output logic [XLEN-1:0] id_ex_readdat2,
    output logic [XLEN-1:0] id_ex_sign_ext,
    output logic [RAW-1:0]  id_ex_instr_bits_25_21,
    output logic [RAW-1:0]  id_ex_instr_bits_20_16,
    output logic [RAW-1:0]  id_ex_instr_bits_15_11
);

    logic [OP_W-1:0] opcode;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd;
    ctrl_t           ctrl;
    logic [XLEN-1:0] sext;
    logic            use_rt;

    // Field extraction and control decode
    always_comb begin
        opcode = if_id_instr[31:26];
        rs     = if_id_instr[21 +: RAW];
        rt     = if_id_instr[16 +: RAW];
        rd     = if_id_instr[11 +: RAW];
        ctrl   = decode_ctrl(opcode);
        sext   = XLEN'($signed(if_id_instr[15:0]));
        // lw and addi use rt as a destination, not a source
        use_rt = !((opcode == OP_LW) || (opcode == OP_ADDI));
    end

    // Register file
    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    always_comb begin
        wr_en = wb_reg_write && (wb_write_reg_location != '0);
        rd1   = '0;
        rd2   = '0;
        if (rs != '0) rd1 = (wr_en && wb_write_reg_location == rs) ? mem_wb_write_data : regs_q[rs];
        if (rt != '0) rd2 = (wr_en && wb_write_reg_location == rt) ? mem_wb_write_data : regs_q[rt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wb_write_reg_location] <= mem_wb_write_data;
        end
    end

    // Hazard detection against the load currently in ID/EX
    logic [1:0]      wb_q,   wb_d;
    logic [2:0]      mem_q,  mem_d;
    logic [3:0]      ex_q,   ex_d;
    logic [XLEN-1:0] npc_q,  npc_d;
    logic [XLEN-1:0] rd1_q,  rd1_d;
    logic [XLEN-1:0] rd2_q,  rd2_d;
    logic [XLEN-1:0] sext_q, sext_d;
    logic [RAW-1:0]  rs_q,   rs_d;
    logic [RAW-1:0]  rt_q,   rt_d;
    logic [RAW-1:0]  rd_q,   rd_d;
    logic            stall;

    hazard_unit_ld #(.RAW(RAW)) u_hazard (
        .id_ex_memread_i (mem_q[MEM_MEMREAD]),
        .id_ex_rt_i      (rt_q),
        .rs_i            (rs),
        .rt_i            (rt),
        .use_rt_i        (use_rt),
        .stall_o         (stall)
    );

    // ID/EX next state: hold > bubble > load
    always_comb begin
        wb_d   = wb_q;
        mem_d  = mem_q;
        ex_d   = ex_q;
        npc_d  = npc_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        sext_d = sext_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        rd_d   = rd_q;
        if (!ex_hold) begin
            npc_d  = if_id_npc;
            rd1_d  = rd1;
            rd2_d  = rd2;
            sext_d = sext;
            rs_d   = rs;
            rt_d   = rt;
            rd_d   = rd;
            if (flush || stall) begin
                wb_d  = CTRL_NOP.wb;
                mem_d = CTRL_NOP.mem;
                ex_d  = CTRL_NOP.ex;
            end else begin
                wb_d  = ctrl.wb;
                mem_d = ctrl.mem;
                ex_d  = ctrl.ex;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q   <= '0;
            mem_q  <= '0;
            ex_q   <= '0;
            npc_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            sext_q <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            wb_q   <= wb_d;
            mem_q  <= mem_d;
            ex_q   <= ex_d;
            npc_q  <= npc_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            sext_q <= sext_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

    assign stall_out              = stall;
    assign id_ex_wb               = wb_q;
    assign id_ex_mem              = mem_q;
    assign id_ex_execute          = ex_q;
    assign id_ex_npc              = npc_q;
    assign id_ex_readdat1         = rd1_q;
    assign id_ex_readdat2         = rd2_q;
    assign id_ex_sign_ext         = sext_q;
    assign id_ex_instr_bits_25_21 = rs_q;
    assign id_ex_instr_bits_20_16 = rt_q;
    assign id_ex_instr_bits_15_11 = rd_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: a default 32-bit instance and a
// 16-bit / 8-register instance driven from one linear stimulus sequence.
module tb_decode_stage_hz;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        wb_reg_write;
    logic [4:0]  wb_loc;
    logic [31:0] wb_data;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        flush;
    logic        ex_hold;
    logic        stall_out;
    logic [1:0]  o_wb;
    logic [2:0]  o_mem;
    logic [3:0]  o_ex;
    logic [31:0] o_npc, o_rd1, o_rd2, o_sext;
    logic [4:0]  o_rs, o_rt, o_rd;

    decode_stage_hz dut (
        .clk                    (clk),
        .rst                    (rst),
        .wb_reg_write           (wb_reg_write),
        .wb_write_reg_location  (wb_loc),
        .mem_wb_write_data      (wb_data),
        .if_id_instr            (instr),
        .if_id_npc              (npc),
        .flush                  (flush),
        .ex_hold                (ex_hold),
        .stall_out              (stall_out),
        .id_ex_wb               (o_wb),
        .id_ex_mem              (o_mem),
        .id_ex_execute          (o_ex),
        .id_ex_npc              (o_npc),
        .id_ex_readdat1         (o_rd1),
        .id_ex_readdat2         (o_rd2),
        .id_ex_sign_ext         (o_sext),
        .id_ex_instr_bits_25_21 (o_rs),
        .id_ex_instr_bits_20_16 (o_rt),
        .id_ex_instr_bits_15_11 (o_rd)
    );

    // 16-bit, 8-register instance
    logic        s_wb_reg_write;
    logic [2:0]  s_wb_loc;
    logic [15:0] s_wb_data;
    logic [31:0] s_instr;
    logic [15:0] s_npc;
    logic        s_stall;
    logic [1:0]  s_wb;
    logic [2:0]  s_mem;
    logic [3:0]  s_ex;
    logic [15:0] s_onpc, s_rd1, s_rd2, s_sext;
    logic [2:0]  s_rs, s_rt, s_rd;

    decode_stage_hz #(.XLEN(16), .NREG(8)) dut16 (
        .clk                    (clk),
        .rst                    (rst),
        .wb_reg_write           (s_wb_reg_write),
        .wb_write_reg_location  (s_wb_loc),
        .mem_wb_write_data      (s_wb_data),
        .if_id_instr            (s_instr),
        .if_id_npc              (s_npc),
        .flush                  (1'b0),
        .ex_hold                (1'b0),
        .stall_out              (s_stall),
        .id_ex_wb               (s_wb),
        .id_ex_mem              (s_mem),
        .id_ex_execute          (s_ex),
        .id_ex_npc              (s_onpc),
        .id_ex_readdat1         (s_rd1),
        .id_ex_readdat2         (s_rd2),
        .id_ex_sign_ext         (s_sext),
        .id_ex_instr_bits_25_21 (s_rs),
        .id_ex_instr_bits_20_16 (s_rt),
        .id_ex_instr_bits_15_11 (s_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs_, input int rt_, input int rd_);
        return {6'h00, 5'(rs_), 5'(rt_), 5'(rd_), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs_, input int rt_,
                                          input logic [15:0] imm);
        return {op, 5'(rs_), 5'(rt_), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP_I = 32'hFC00_0000;

    initial begin
        rst = 1'b0;
        wb_reg_write = 1'b0; wb_loc = '0; wb_data = '0;
        instr = NOP_I; npc = '0; flush = 1'b0; ex_hold = 1'b0;
        s_wb_reg_write = 1'b0; s_wb_loc = '0; s_wb_data = '0; s_instr = NOP_I; s_npc = '0;

        // Reset state
        #1;
        check("rst_wb",    64'(o_wb), 64'h0);
        check("rst_mem",   64'(o_mem), 64'h0);
        check("rst_stall", 64'(stall_out), 64'h0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("nop_ctrl", 64'({o_wb, o_mem, o_ex}), 64'h0);

        // Bypass: write r5 while decoding add r1,r5,r5
        wb_reg_write = 1'b1; wb_loc = 5'd5; wb_data = 32'hDEAD_BEEF;
        instr = rtype(5, 5, 1); npc = 32'h100;
        tick();
        check("byp_rd1",  64'(o_rd1), 64'hDEAD_BEEF);
        check("byp_rd2",  64'(o_rd2), 64'hDEAD_BEEF);
        check("add_ctrl", 64'({o_wb, o_mem, o_ex}), 64'({2'b10, 3'b000, 4'b1100}));
        check("add_npc",  64'(o_npc), 64'h100);
        check("add_flds", 64'({o_rs, o_rt, o_rd}), 64'({5'd5, 5'd5, 5'd1}));
        check("add_sext", 64'(o_sext), 64'h0000_0820);

        // Stored value, r0 reads zero
        wb_reg_write = 1'b0;
        instr = rtype(5, 0, 2);
        tick();
        check("rf_r5", 64'(o_rd1), 64'hDEAD_BEEF);
        check("rf_r0", 64'(o_rd2), 64'h0);

        // Preload r2, r4; r0 write is ignored and not bypassed
        wb_reg_write = 1'b1; wb_loc = 5'd2; wb_data = 32'h1000; instr = NOP_I;
        tick();
        wb_loc = 5'd4; wb_data = 32'h44;
        tick();
        wb_loc = 5'd0; wb_data = 32'h1234_5678; instr = rtype(0, 0, 1);
        tick();
        check("r0_nobyp", 64'(o_rd1), 64'h0);
        wb_reg_write = 1'b0;
        tick();
        check("r0_nowr", 64'(o_rd1), 64'h0);

        // Load-use: lw r8,0(r2) then add r3,r8,r4
        instr = itype(6'h23, 2, 8, 16'h0);
        tick();
        check("lw_ctrl", 64'({o_wb, o_mem, o_ex}), 64'({2'b11, 3'b010, 4'b0001}));
        check("lw_base", 64'(o_rd1), 64'h1000);
        instr = rtype(8, 4, 3);
        #1;
        check("lu_stall", 64'(stall_out), 64'h1);
        tick();
        check("bubble_ctrl", 64'({o_wb, o_mem, o_ex}), 64'h0);
        check("bubble_data", 64'(o_rd2), 64'h44);
        check("stall_1cyc", 64'(stall_out), 64'h0);
        tick();
        check("add_after", 64'({o_wb, o_ex}), 64'({2'b10, 4'b1100}));

        // No false stall; rt used by sw, rs used by addi
        instr = itype(6'h23, 2, 8, 16'h0);
        tick();
        instr = itype(6'h08, 1, 8, 16'h4);
        #1;
        check("addi_rt_nostall", 64'(stall_out), 64'h0);
        instr = itype(6'h2B, 1, 8, 16'h0);
        #1;
        check("sw_rt_stall", 64'(stall_out), 64'h1);
        instr = itype(6'h08, 8, 9, 16'h4);
        #1;
        check("addi_rs_stall", 64'(stall_out), 64'h1);

        // Hold during stall: latch frozen, stall still driven
        ex_hold = 1'b1;
        instr = rtype(8, 4, 3);
        tick();
        check("hold_lw_mem", 64'(o_mem), 64'b010);
        check("hold_stall",  64'(stall_out), 64'h1);
        ex_hold = 1'b0;
        tick();
        check("hold_rel_bubble", 64'({o_wb, o_mem, o_ex}), 64'h0);

        // Load into r0 never stalls
        instr = itype(6'h23, 2, 0, 16'h0);
        tick();
        instr = rtype(0, 0, 3);
        #1;
        check("rt0_nostall", 64'(stall_out), 64'h0);

        // Flush vs hold
        instr = itype(6'h08, 2, 7, 16'h5); flush = 1'b1; npc = 32'h200;
        tick();
        check("flush_ctrl", 64'({o_wb, o_mem, o_ex}), 64'h0);
        check("flush_data", 64'(o_rd1), 64'h1000);
        flush = 1'b0;
        tick();
        check("addi_ctrl", 64'({o_wb, o_mem, o_ex}), 64'({2'b10, 3'b000, 4'b0001}));
        ex_hold = 1'b1; flush = 1'b1;
        instr = itype(6'h23, 4, 10, 16'hFFFC); npc = 32'h300;
        tick();
        check("hf_ctrl", 64'({o_wb, o_mem, o_ex}), 64'({2'b10, 3'b000, 4'b0001}));
        check("hf_sext", 64'(o_sext), 64'h5);
        check("hf_npc",  64'(o_npc), 64'h200);
        ex_hold = 1'b0;
        tick();
        check("rel_flush_ctrl", 64'({o_wb, o_mem, o_ex}), 64'h0);
        check("rel_sext_neg",   64'(o_sext), 64'hFFFF_FFFC);
        flush = 1'b0;

        // Mid-stream async reset
        instr = itype(6'h23, 2, 8, 16'h0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_mem",   64'(o_mem), 64'h0);
        check("async_rd1",   64'(o_rd1), 64'h0);
        check("async_stall", 64'(stall_out), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        instr = rtype(5, 2, 1);
        tick();
        check("post_rst_r5", 64'(o_rd1), 64'h0);
        check("post_rst_r2", 64'(o_rd2), 64'h0);

        // 16-bit / 8-register instance
        s_wb_reg_write = 1'b1; s_wb_loc = 3'd0; s_wb_data = 16'hBEEF;
        s_instr = itype(6'h08, 0, 3, 16'h8001);
        tick();
        check("w16_sext",  64'(s_sext), 64'h8001);
        check("w16_r0byp", 64'(s_rd1), 64'h0);
        s_wb_loc = 3'd3; s_wb_data = 16'h1234; s_instr = NOP_I;
        tick();
        s_wb_reg_write = 1'b0;
        s_instr = rtype(11, 0, 1);
        tick();
        check("w16_rs_trunc", 64'(s_rs), 64'h3);
        check("w16_rd_r3",    64'(s_rd1), 64'h1234);
        check("w16_r0_kept",  64'(s_rd2), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised instruction-decode stage for the MIPS pipeline. Sits between the IF/ID and ID/EX boundaries and produces the registered ID/EX bundle. It adds three things to the basic decode-plus-latch arrangement: a configurable data width and register count, write-through bypass in the register file, and a load-use hazard unit with bubble insertion. It also supports flush and hold control from the rest of the pipeline.

## Interface
Parameters:
- XLEN, 32, data/instruction-address width; instruction word is fixed at 32 bits
- NREG, 32, architectural register count (power of two, ≥ 2); RAW = $clog2(NREG)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_reg_write  in  1  writeback enable
- wb_write_reg_location  in  RAW  writeback destination
- mem_wb_write_data  in  XLEN  writeback data
- if_id_instr  in  32  instruction from IF/ID
- if_id_npc  in  XLEN  next PC from IF/ID
- flush  in  1  branch/jump squash of the instruction currently in ID
- ex_hold  in  1  downstream stall; ID/EX contents freeze
- stall_out  out  1  load-use stall; IF must hold PC and IF/ID
- id_ex_wb  out  2  {RegWrite, MemtoReg}
- id_ex_mem  out  3  {Branch, MemRead, MemWrite}
- id_ex_execute  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext  out  XLEN  latched operands
- id_ex_instr_bits_25_21, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11  out  RAW  latched rs/rt/rd (low RAW bits of each field)

## Operation
- Control decode (opcode = instr[31:26]):
  - 0x00 R-type: wb=10, mem=000, ex=1_10_0
  - 0x23 lw: wb=11, mem=010, ex=0_00_1
  - 0x2B sw: wb=00, mem=001, ex=0_00_1
  - 0x04 beq: wb=00, mem=100, ex=0_01_0
  - 0x08 addi: wb=10, mem=000, ex=0_00_1
  - any other opcode: all zero (NOP)
- Sign extension: instr[15:0] sign-extended to XLEN.
- Register file: NREG×XLEN, two combinational read ports, one write port.
  - Write occurs at the rising edge when wb_reg_write=1 and the address is nonzero.
  - Register 0 always reads 0.
  - Bypass: if wb_reg_write=1, the write address is nonzero and equals rs (or rt), the read returns mem_wb_write_data in the same cycle.
- Hazard unit:
  - stall_out = id_ex_mem[1] (MemRead) && id_ex_rt != 0 && (id_ex_rt == rs || id_ex_rt == rt).
  - It also depends on the current opcode reading the register: rt is ignored for lw and addi.
- ID/EX latch update, in priority order at each rising edge:
  1. ex_hold=1: all fields keep their value. This applies even with flush or stall asserted; stall_out is still driven.
  2. flush=1 or stall_out=1: control fields (wb/mem/execute) load 0 (bubble); data fields load normally.
  3. Otherwise: every field loads the decoded values.
- Outputs are zero after reset; stall_out=0 after reset because the latched MemRead is 0.

## Timing
- Decode → ID/EX has one-cycle latency. The register-file write and the latch update happen on the same edge. The bypass means a result written in cycle N is visible to the instruction decoded in cycle N.
- stall_out is combinational from if_id_instr and the latch contents. It is held for exactly one cycle per load-use pair, because the bubble clears MemRead on the next edge.
- Asserting rst mid-operation immediately zeroes every register-file entry and every latch field, independent of clk.
- wb_write_reg_location = 0 with wb_reg_write = 1: no write and no bypass.

## Structure
- Package decode_pkg contains:
  - opcode localparams
  - control bit-field widths and positions
  - the per-opcode control constants
  - a NOP control constant
- One sub-module: hazard_unit_ld (combinational load-use compare, parametrised on RAW).
- Register file and latch are inline always blocks; the latch uses async reset.

## Test plan
- Reset: drive rst=0 mid-stream → all id_ex_* = 0 and stall_out = 0 immediately; registers read 0 after release.
- Bypass: write r5 = 0xDEADBEEF while decoding `add r1,r5,r5` → id_ex_readdat1 = id_ex_readdat2 = 0xDEADBEEF on the next edge.
- Load-use: `lw r8,0(r2)` followed by `add r3,r8,r4` → stall_out = 1 for one cycle, bubble controls = 0. The add then latches on the following edge with wb=10.
- No false stall: `lw r8` followed by `addi r9,r8`… where only rt matches (`addi r8,r1,4`) → stall_out = 0. Same result when id_ex_rt = 0.
- Flush vs hold: flush=1 → controls 0 next edge. ex_hold=1 together with flush → latch unchanged. Release hold → flush takes effect.
- Width: instantiate XLEN=16, NREG=8 → `addi` with imm 0x8001 gives id_ex_sign_ext = 0x8001; r0 writes are ignored.
